// File: rtl/alu_pkg.sv
// Opcode encodings, opcode legality check and FSM state type shared by the ALU issuer files.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_SLL = 4'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } issuer_state_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_SLL);
    endfunction

endpackage

// File: rtl/alu_carry_calc.sv
// Local carry/borrow for ADD and SUB, computed from the operands held on the ALU inputs.
// Only instantiated by alu_op_issuer when ALU_ISSUER_CARRY_EN is defined.
module alu_carry_calc
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             carry
);

    logic add_carry;
    logic sub_borrow;

    // Bit WIDTH of the zero-extended sum; the borrow of a-b is simply a<b.
    assign add_carry  = 1'(({1'b0, a} + {1'b0, b}) >> WIDTH);
    assign sub_borrow = (a < b);

    always_comb begin
        carry = 1'b0;
        case (op)
            OP_ADD:  carry = add_carry;
            OP_SUB:  carry = sub_borrow;
            default: carry = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one command at a time to a combinational ALU, waits SETTLE cycles and returns result/flags.
// Build option ALU_ISSUER_CARRY_EN: rsp_carry computed locally (alu_carry_calc) instead of from alu_carry.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SHW    = 5,
    parameter int SETTLE = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SHW-1:0]   cmd_shamt,
    input  logic [TAG_W-1:0] cmd_tag,

    output logic [OP_W-1:0]  alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [SHW-1:0]   alu_shift,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_sign,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_sign,
    output logic             rsp_carry,
    output logic             rsp_illegal,
    output logic [TAG_W-1:0] rsp_tag,

    output logic             busy
);

    localparam int CNT_W = $clog2(SETTLE + 1);

    issuer_state_t    state;
    issuer_state_t    state_next;
    logic [CNT_W-1:0] settle_cnt;
    logic [TAG_W-1:0] tag_q;
    logic             accept;
    logic             capture;
    logic             cmd_legal;
    logic             carry_src;

    assign cmd_legal = is_legal_op(cmd_op);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

`ifdef ALU_ISSUER_CARRY_EN
    alu_carry_calc #(
        .WIDTH (WIDTH)
    ) u_carry_calc (
        .op    (alu_opcode),
        .a     (alu_input1),
        .b     (alu_input2),
        .carry (carry_src)
    );
`else
    assign carry_src = alu_carry;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // In RESP a new command is only taken when the pending response retires on the same edge.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        capture    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            WAIT:    capture   = (settle_cnt == CNT_W'(1));
            RESP:    cmd_ready = rsp_ready;
            default: cmd_ready = 1'b0;
        endcase
        if (rst) begin
            cmd_ready = 1'b0;
        end
        accept = cmd_valid && cmd_ready;
        if (accept) begin
            state_next = cmd_legal ? WAIT : RESP;
        end else if (capture) begin
            state_next = RESP;
        end else if ((state == RESP) && rsp_ready) begin
            state_next = IDLE;
        end
    end

    // Illegal opcodes never reach the ALU ports; they get a canned response immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_opcode  <= '0;
            alu_input1  <= '0;
            alu_input2  <= '0;
            alu_shift   <= '0;
            settle_cnt  <= '0;
            tag_q       <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_sign    <= 1'b0;
            rsp_carry   <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_tag     <= '0;
        end else begin
            if (accept && cmd_legal) begin
                alu_opcode <= cmd_op;
                alu_input1 <= cmd_a;
                alu_input2 <= cmd_b;
                alu_shift  <= cmd_shamt;
                settle_cnt <= CNT_W'(SETTLE);
                tag_q      <= cmd_tag;
            end else if (accept) begin
                rsp_result  <= '0;
                rsp_zero    <= 1'b1;
                rsp_sign    <= 1'b0;
                rsp_carry   <= 1'b0;
                rsp_illegal <= 1'b1;
                rsp_tag     <= cmd_tag;
            end
            if (state == WAIT) begin
                settle_cnt <= settle_cnt - CNT_W'(1);
            end
            if (capture) begin
                rsp_result  <= alu_result;
                rsp_zero    <= alu_zero;
                rsp_sign    <= alu_sign;
                rsp_carry   <= carry_src;
                rsp_illegal <= 1'b0;
                rsp_tag     <= tag_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed self-checking bench for alu_op_issuer (WIDTH=16, SETTLE=2) with a 16-bit ALU model attached.
module tb_alu_op_issuer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic [4:0]  cmd_shamt;
    logic [3:0]  cmd_tag;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_input1;
    logic [15:0] alu_input2;
    logic [4:0]  alu_shift;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_sign;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_sign;
    logic        rsp_carry;
    logic        rsp_illegal;
    logic [3:0]  rsp_tag;
    logic        busy;

    int testsRun = 0;
    int testsFailed = 0;

    alu_op_issuer #(
        .WIDTH  (16),
        .SHW    (5),
        .SETTLE (2),
        .TAG_W  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_shamt   (cmd_shamt),
        .cmd_tag     (cmd_tag),
        .alu_opcode  (alu_opcode),
        .alu_input1  (alu_input1),
        .alu_input2  (alu_input2),
        .alu_shift   (alu_shift),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .alu_zero    (alu_zero),
        .alu_sign    (alu_sign),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_sign    (rsp_sign),
        .rsp_carry   (rsp_carry),
        .rsp_illegal (rsp_illegal),
        .rsp_tag     (rsp_tag),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The attached ALU: carry is ADD carry-out and SUB borrow, matching the local-carry option.
    always_comb begin
        alu_result = 16'h0000;
        alu_carry  = 1'b0;
        case (alu_opcode)
            4'd0: {alu_carry, alu_result} = {1'b0, alu_input1} + {1'b0, alu_input2};
            4'd1: begin
                alu_result = alu_input1 - alu_input2;
                alu_carry  = (alu_input1 < alu_input2);
            end
            4'd2: alu_result = alu_input1 & alu_input2;
            4'd3: alu_result = alu_input1 | alu_input2;
            4'd4: alu_result = alu_input1 << alu_shift;
            default: alu_result = 16'h0000;
        endcase
        alu_zero = (alu_result == 16'h0000);
        alu_sign = alu_result[15];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [4:0] shamt, input logic [3:0] tag);
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_shamt = shamt;
        cmd_tag   = tag;
        cmd_valid = 1'b1;
    endtask

    // Called right after the accepting edge; counts further edges until rsp_valid (bounded).
    task automatic waitRsp(input string name, input int expLat, input logic checkShift, input logic [4:0] shamt);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 8) begin
            if (checkShift) checkOutput({name, " alu_shift"}, alu_shift, shamt);
            tick();
            lat++;
        end
        checkOutput({name, " latency"}, lat, expLat);
    endtask

    task automatic checkRsp(input string name, input logic [15:0] result, input logic zero, input logic sign,
                            input logic carry, input logic illegal, input logic [3:0] tag);
        checkOutput({name, " rsp_valid"},   rsp_valid,   1'b1);
        checkOutput({name, " rsp_result"},  rsp_result,  result);
        checkOutput({name, " rsp_zero"},    rsp_zero,    zero);
        checkOutput({name, " rsp_sign"},    rsp_sign,    sign);
        checkOutput({name, " rsp_carry"},   rsp_carry,   carry);
        checkOutput({name, " rsp_illegal"}, rsp_illegal, illegal);
        checkOutput({name, " rsp_tag"},     rsp_tag,     tag);
    endtask

    task automatic retire(input string name);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput({name, " retired"}, rsp_valid, 1'b0);
        checkOutput({name, " idle"},    busy,      1'b0);
    endtask

    task automatic runCmd(input string name, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] shamt, input logic [3:0] tag, input int expLat);
        applyStimulus(op, a, b, shamt, tag);
        #1;
        checkOutput({name, " cmd_ready"}, cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        waitRsp(name, expLat, (expLat != 0), shamt);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        cmd_op    = 4'd0;
        cmd_a     = 16'h0000;
        cmd_b     = 16'h0000;
        cmd_shamt = 5'd0;
        cmd_tag   = 4'd0;
        tick();
        tick();

        checkOutput("reset cmd_ready", cmd_ready,  1'b0);
        checkOutput("reset busy",      busy,       1'b0);
        checkOutput("reset rsp_valid", rsp_valid,  1'b0);
        checkOutput("reset alu_input1", alu_input1, 16'h0000);
        checkOutput("reset rsp_zero",  rsp_zero,   1'b0);
        rst = 1'b0;

        runCmd("add", 4'd0, 16'hFFFF, 16'h0001, 5'd0, 4'd3, 2);
        checkRsp("add", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3);
        retire("add");

        runCmd("sub", 4'd1, 16'h0003, 16'h0005, 5'd0, 4'd5, 2);
        checkRsp("sub", 16'hFFFE, 1'b0, 1'b1, 1'b1, 1'b0, 4'd5);
        retire("sub");

        runCmd("sll", 4'd4, 16'h0001, 16'h0000, 5'd15, 4'd6, 2);
        checkRsp("sll", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
        retire("sll");

        // Illegal opcode answers in the cycle right after the accepting edge and leaves alu_* alone.
        runCmd("illegal", 4'd7, 16'h1234, 16'h5678, 5'd3, 4'd9, 0);
        checkRsp("illegal", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd9);
        checkOutput("illegal alu_opcode", alu_opcode, 4'd4);
        checkOutput("illegal alu_input1", alu_input1, 16'h0001);
        retire("illegal");

        runCmd("or", 4'd3, 16'h1200, 16'h0034, 5'd0, 4'd10, 2);
        applyStimulus(4'd2, 16'h00F0, 16'h0F0F, 5'd0, 4'd11);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp cmd_ready", cmd_ready, 1'b0);
            checkRsp("bp", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp same-edge cmd_ready", cmd_ready, 1'b1);
        tick();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        checkOutput("bp and rsp_valid", rsp_valid, 1'b0);
        checkOutput("bp and alu_opcode", alu_opcode, 4'd2);
        waitRsp("bp and", 2, 1'b1, 5'd0);
        checkRsp("bp and", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'd11);
        retire("bp and");

        applyStimulus(4'd0, 16'h0100, 16'h0200, 5'd7, 4'd12);
        tick();
        cmd_valid = 1'b0;
        checkOutput("rst wait busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rst cmd_ready", cmd_ready, 1'b0);
        tick();
        checkOutput("rst busy",       busy,       1'b0);
        checkOutput("rst rsp_valid",  rsp_valid,  1'b0);
        checkOutput("rst alu_opcode", alu_opcode, 4'd0);
        checkOutput("rst alu_input1", alu_input1, 16'h0000);
        checkOutput("rst alu_input2", alu_input2, 16'h0000);
        checkOutput("rst alu_shift",  alu_shift,  5'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst no response", rsp_valid, 1'b0);
        end

        runCmd("post-rst add", 4'd0, 16'h7FFF, 16'h0001, 5'd0, 4'd13, 2);
        checkRsp("post-rst add", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd13);
        retire("post-rst add");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
